reset: RTL and testbench
========================

Name: reset

Overview:
- Post-spike membrane-potential reset stage of the neuron datapath.
- Sits between the potential adder and potential memory.
- Takes the accumulated potential (IEEE-754 single precision) and the spike flag.
- Writes back either the unchanged potential or the potential reduced by the threshold (reset-by-subtraction).
- Output is registered: one clock of latency.

Parameters:
- None. Data width is fixed at 32 bits (IEEE-754 binary32).

Ports:
- CLK  input  1  system clock, rising edge active
- RESET_N  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies adder_potential / spiked / v_threshold this cycle
- adder_potential  input  32  binary32 potential from the adder stage
- spiked  input  1  1 = neuron fired this timestep
- v_threshold  input  32  binary32 firing threshold
- potential_to_mem  output  32  binary32 potential to write to memory
- out_valid  output  1  potential_to_mem is valid
- Exception  output  1  result is NaN/Inf or an operand was NaN/Inf

Behaviour:
- RESET_N low (asynchronous): potential_to_mem = 32'h0000_0000, out_valid = 0, Exception = 0. Outputs are held while low.
- Inputs are sampled on rising CLK when in_valid = 1. Results appear after the same edge (latency 1).
- out_valid = registered in_valid. When in_valid = 0, potential_to_mem and Exception hold their previous values.
- spiked = 0: potential_to_mem = adder_potential, passed bit-exact. v_threshold is ignored. Exception = 1 only if adder_potential has exponent 8'hFF.
- spiked = 1: potential_to_mem = adder_potential − v_threshold, computed as binary32 subtraction:
  - Operands with exponent 0 (zero/denormal) are flushed to signed zero before the operation.
  - Align by right-shifting the smaller magnitude, keeping guard/round/sticky bits.
  - Round to nearest, ties to even.
  - Exact cancellation gives +0.0 (32'h0000_0000).
  - Underflowed result (exponent ≤ 0) is flushed to +0.0.
  - Overflow gives ±Inf (exponent FF, mantissa 0) with Exception = 1.
  - Any NaN operand, or Inf−Inf, gives canonical NaN 32'h7FC0_0000 with Exception = 1.
  - Any other Inf operand gives the correctly signed Inf with Exception = 1.
- spiked has no effect when in_valid = 0.
- No back-pressure. A new operation may be accepted every cycle.
- RESET_N asserted mid-operation: the in-flight result is discarded, outputs go to reset values immediately.

Optional Feature:
- Macro RESET_TO_ZERO_EN.
- Defined: spiked = 1 forces potential_to_mem = 32'h0000_0000 (hard reset to zero). Exception then reflects only adder_potential NaN/Inf. The subtractor logic is not synthesized.
- Undefined: reset-by-subtraction as specified above.
- spiked = 0 behaviour, latency and reset values are identical in both builds.

Test Plan:
- adder_potential = 32'h4178_0000 (15.5), v_threshold = 32'h4178_0000, spiked = 1, in_valid = 1 → next edge: potential_to_mem = 32'h0000_0000, out_valid = 1, Exception = 0. Same result with RESET_TO_ZERO_EN.
- adder_potential = 32'h4178_0000, spiked = 0 → potential_to_mem = 32'h4178_0000, Exception = 0.
- adder_potential = 32'h41A0_0000 (20.0), v_threshold = 32'h4178_0000, spiked = 1 → 32'h4090_0000 (4.5); with RESET_TO_ZERO_EN → 32'h0000_0000.
- adder_potential = 32'h4120_0000 (10.0), v_threshold = 32'h4178_0000, spiked = 1 → 32'hC0B0_0000 (−5.5).
- adder_potential = 32'h7F80_0000 (+Inf), v_threshold = 32'h7F80_0000, spiked = 1 → 32'h7FC0_0000, Exception = 1.
- Drive valid traffic, then pull RESET_N low between edges → potential_to_mem = 0, out_valid = 0, Exception = 0 immediately. Release RESET_N, apply in_valid = 0 → outputs stay 0. Next valid input gives a correct result one cycle later.

Source files
------------

// File: rtl/reset.sv
// Post-spike membrane reset: passes the potential through, or subtracts the threshold on a spike (binary32).
// Build option: define RESET_TO_ZERO_EN to replace reset-by-subtraction with a hard reset to zero.
module reset (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        in_valid,
  input  logic [31:0] adder_potential,
  input  logic        spiked,
  input  logic [31:0] v_threshold,
  output logic [31:0] potential_to_mem,
  output logic        out_valid,
  output logic        Exception
);

  logic [31:0] pot_d, pot_q;
  logic        valid_d, valid_q;
  logic        exc_d, exc_q;
  logic [31:0] res;
  logic        res_exc;
  logic        a_special;

  assign a_special = (adder_potential[30:23] == 8'hFF);

`ifndef RESET_TO_ZERO_EN
  logic              sa, sb, sx, sy, swap;
  logic [7:0]        ea, eb, ex, ey, diff;
  logic [23:0]       ma, mb, mx, my;
  logic              a_nan, b_nan, a_inf, b_inf;
  logic [4:0]        shamt, lz;
  logic [26:0]       x_ext, y_aligned, norm;
  logic [53:0]       y_wide;
  logic [27:0]       sum;
  logic signed [9:0] exp_n, exp_r;
  logic              round_up;
  logic [32:0]       rounded;
  logic [31:0]       sub_res;
  logic              sub_exc;

  // a - b is evaluated as a + (-b), so the threshold sign is inverted up front
  always_comb begin
    sa    = adder_potential[31];
    sb    = ~v_threshold[31];
    ea    = adder_potential[30:23];
    eb    = v_threshold[30:23];
    a_nan = (ea == 8'hFF) && (adder_potential[22:0] != 23'd0);
    b_nan = (eb == 8'hFF) && (v_threshold[22:0] != 23'd0);
    a_inf = (ea == 8'hFF) && (adder_potential[22:0] == 23'd0);
    b_inf = (eb == 8'hFF) && (v_threshold[22:0] == 23'd0);
    ma    = (ea == 8'd0) ? 24'd0 : {1'b1, adder_potential[22:0]};
    mb    = (eb == 8'd0) ? 24'd0 : {1'b1, v_threshold[22:0]};

    swap  = {eb, mb} > {ea, ma};
    sx    = swap ? sb : sa;
    sy    = swap ? sa : sb;
    ex    = swap ? eb : ea;
    ey    = swap ? ea : eb;
    mx    = swap ? mb : ma;
    my    = swap ? ma : mb;

    diff      = ex - ey;
    shamt     = (diff > 8'd27) ? 5'd27 : diff[4:0];
    x_ext     = {mx, 3'b000};
    y_wide    = {my, 3'b000, 27'd0} >> shamt;
    y_aligned = y_wide[53:27] | {26'd0, |y_wide[26:0]};

    sum = (sx == sy) ? ({1'b0, x_ext} + {1'b0, y_aligned})
                     : ({1'b0, x_ext} - {1'b0, y_aligned});

    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    if (sum[27]) begin
      norm  = sum[27:1] | {26'd0, sum[0]};
      exp_n = $signed({2'b00, ex}) + 10'sd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_n = $signed({2'b00, ex}) - $signed({5'd0, lz});
    end

    // Mantissa carry from rounding ripples straight into the exponent field
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {exp_n, norm[25:3]} + {32'd0, round_up};
    exp_r    = $signed(rounded[32:23]);

    sub_res = 32'h0000_0000;
    sub_exc = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      sub_res = 32'h7FC0_0000;
      sub_exc = 1'b1;
    end else if (a_inf) begin
      sub_res = {sa, 8'hFF, 23'd0};
      sub_exc = 1'b1;
    end else if (b_inf) begin
      sub_res = {sb, 8'hFF, 23'd0};
      sub_exc = 1'b1;
    end else if ((ma == 24'd0) && (mb == 24'd0)) begin
      sub_res = {sa & sb, 31'd0};
    end else if (!norm[26] || (exp_r <= 10'sd0)) begin
      sub_res = 32'h0000_0000;
    end else if (exp_r >= 10'sd255) begin
      sub_res = {sx, 8'hFF, 23'd0};
      sub_exc = 1'b1;
    end else begin
      sub_res = {sx, exp_r[7:0], rounded[22:0]};
    end
  end
`endif

  always_comb begin
    res     = adder_potential;
    res_exc = a_special;
    if (spiked) begin
`ifdef RESET_TO_ZERO_EN
      res     = 32'h0000_0000;
`else
      res     = sub_res;
      res_exc = sub_exc;
`endif
    end
    valid_d = in_valid;
    pot_d   = in_valid ? res : pot_q;
    exc_d   = in_valid ? res_exc : exc_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pot_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      pot_q   <= pot_d;
      valid_q <= valid_d;
      exc_q   <= exc_d;
    end
  end

  assign potential_to_mem = pot_q;
  assign out_valid        = valid_q;
  assign Exception        = exc_q;

endmodule

// File: tb/tb_reset.sv
// Scoreboard bench for the membrane reset stage: directed corner cases, random traffic, mid-run reset.
module tb_reset;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] adder_potential = 32'd0;
  logic        spiked = 1'b0;
  logic [31:0] v_threshold = 32'd0;
  logic [31:0] potential_to_mem;
  logic        out_valid;
  logic        Exception;

  typedef struct packed {
    logic [31:0] pot;
    logic        exc;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_pot = 32'd0;
  logic        last_exc = 1'b0;

  reset dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .in_valid         (in_valid),
    .adder_potential  (adder_potential),
    .spiked           (spiked),
    .v_threshold      (v_threshold),
    .potential_to_mem (potential_to_mem),
    .out_valid        (out_valid),
    .Exception        (Exception)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%08h want=%08h", tag, got, want);
    end
  endtask

  // binary32 -> real via a hand-built double; zero/denormal exponents flush to 0.0
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  // real -> binary32 with round-to-nearest-even; operands are chosen so the result stays normal
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic        up;
    logic [30:0] body;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'h0000_0000;
    e    = d[62:52] - 11'd896;
    up   = d[28] & ((|d[27:0]) | d[29]);
    body = {e[7:0], d[51:29]} + {30'd0, up};
    return {d[63], body};
  endfunction

  function automatic exp_t pick(input logic [31:0] a, input logic s,
                                input logic [31:0] sub_pot, input logic sub_exc);
    exp_t r;
    if (!s) begin
      r.pot = a;
      r.exc = (a[30:23] == 8'hFF);
    end else begin
`ifdef RESET_TO_ZERO_EN
      r.pot = 32'h0000_0000;
      r.exc = (a[30:23] == 8'hFF);
`else
      r.pot = sub_pot;
      r.exc = sub_exc;
`endif
    end
    return r;
  endfunction

  task automatic xact(input string tag, input logic v, input logic [31:0] a, input logic s,
                      input logic [31:0] b, input exp_t e);
    exp_t x;
    in_valid        = v;
    adder_potential = a;
    spiked          = s;
    v_threshold     = b;
    if (v) sb_q.push_back(e);
    @(posedge CLK);
    #1;
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    if (v) begin
      if (sb_q.size() == 0) begin
        check({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
        x = sb_q.pop_front();
        check({tag, ".pot"}, potential_to_mem, x.pot);
        check({tag, ".exc"}, {31'd0, Exception}, {31'd0, x.exc});
        last_pot = x.pot;
        last_exc = x.exc;
      end
    end else begin
      check({tag, ".hold_pot"}, potential_to_mem, last_pot);
      check({tag, ".hold_exc"}, {31'd0, Exception}, {31'd0, last_exc});
    end
    $display("xact %s v=%0d a=%08h s=%0d b=%08h -> pot=%08h ov=%0d exc=%0d",
             tag, v, a, s, b, potential_to_mem, out_valid, Exception);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] pot;
    logic        exc;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] a, b;
    logic        v, s;
    exp_t        e;

    vecs[0]  = '{"eq_cancel",  32'h4178_0000, 32'h4178_0000, 1'b1, 32'h0000_0000, 1'b0};
    vecs[1]  = '{"pass",       32'h4178_0000, 32'h4178_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[2]  = '{"sub_pos",    32'h41A0_0000, 32'h4178_0000, 1'b1, 32'h4090_0000, 1'b0};
    vecs[3]  = '{"sub_neg",    32'h4120_0000, 32'h4178_0000, 1'b1, 32'hC0B0_0000, 1'b0};
    vecs[4]  = '{"inf_inf",    32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b1};
    vecs[5]  = '{"pass_inf",   32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[6]  = '{"nan_a",      32'h7FC1_2345, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, 1'b1};
    vecs[7]  = '{"inf_b",      32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 1'b1};
    vecs[8]  = '{"overflow",   32'h7F7F_FFFF, 32'hFF7F_FFFF, 1'b1, 32'h7F80_0000, 1'b1};
    vecs[9]  = '{"denorm_a",   32'h0040_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 1'b0};
    vecs[10] = '{"underflow",  32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 1'b0};
    vecs[11] = '{"tie_even",   32'h3F80_0000, 32'hB380_0000, 1'b1, 32'h3F80_0000, 1'b0};
    vecs[12] = '{"tie_up",     32'h3F80_0001, 32'hB380_0000, 1'b1, 32'h3F80_0002, 1'b0};
    vecs[13] = '{"inf_m_ninf", 32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7F80_0000, 1'b1};
    vecs[14] = '{"ninf_a",     32'hFF80_0000, 32'h3F80_0000, 1'b1, 32'hFF80_0000, 1'b1};

    #12;
    check("rst.pot",   potential_to_mem,       32'h0000_0000);
    check("rst.valid", {31'd0, out_valid},     32'd0);
    check("rst.exc",   {31'd0, Exception},     32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    foreach (vecs[i]) begin
      xact(vecs[i].tag, 1'b1, vecs[i].a, vecs[i].s, vecs[i].b,
           pick(vecs[i].a, vecs[i].s, vecs[i].pot, vecs[i].exc));
    end
    xact("idle", 1'b0, 32'h1234_5678, 1'b1, 32'h4178_0000, '0);

    // Random finite traffic with nearby exponents so the double-precision reference is exact
    for (int n = 0; n < 40; n++) begin
      v = ($urandom_range(4) != 0);
      s = ($urandom_range(2) != 0);
      a = {1'($urandom_range(1)), 8'($urandom_range(135, 120)), 23'($urandom)};
      b = {1'($urandom_range(1)), 8'($urandom_range(135, 120)), 23'($urandom)};
      e = pick(a, s, r2f(f2r(a) - f2r(b)), 1'b0);
      xact($sformatf("rnd%0d", n), v, a, s, b, e);
    end

    // Asynchronous reset between edges while traffic is flowing
    xact("pre_rst", 1'b1, 32'h41A0_0000, 1'b0, 32'h4178_0000,
         pick(32'h41A0_0000, 1'b0, 32'd0, 1'b0));
    #3;
    RESET_N = 1'b0;
    sb_q.delete();
    #1;
    check("arst.pot",   potential_to_mem,   32'h0000_0000);
    check("arst.valid", {31'd0, out_valid}, 32'd0);
    check("arst.exc",   {31'd0, Exception}, 32'd0);
    in_valid        = 1'b1;
    adder_potential = 32'h7F80_0000;
    spiked          = 1'b0;
    @(posedge CLK);
    #1;
    check("arst_hold.pot",   potential_to_mem,   32'h0000_0000);
    check("arst_hold.valid", {31'd0, out_valid}, 32'd0);
    check("arst_hold.exc",   {31'd0, Exception}, 32'd0);
    @(negedge CLK);
    RESET_N  = 1'b1;
    last_pot = 32'h0000_0000;
    last_exc = 1'b0;
    xact("post_idle0", 1'b0, 32'h4120_0000, 1'b1, 32'h4178_0000, '0);
    xact("post_idle1", 1'b0, 32'h4120_0000, 1'b0, 32'h4178_0000, '0);
    xact("post_sub", 1'b1, 32'h41A0_0000, 1'b1, 32'h4178_0000,
         pick(32'h41A0_0000, 1'b1, 32'h4090_0000, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
